// File: rtl/osc_synth.sv
// osc_synth -- numerically controlled square-wave synthesizer.
//
// A phase accumulator adds the frequency word (in kHz) every mclk cycle.
// Each time it reaches half the mclk frequency (in kHz), osc_out toggles,
// so osc_out runs at freq_khz on average. A requested frequency is held in
// a pending register and applied only on a falling edge of osc_out, or at
// once while stopped, so the output never changes frequency mid-pulse.
// Starting and stopping happen only with osc_out low, which prevents runt
// pulses.
//
// Optional feature macro: OSC_SYNTH_EDGE_COUNT_EN adds a saturating
// counter of osc_out rising edges, together with its clear input.
//
// Parameters:
//   ACC_W         accumulator and frequency-word width
//   MCLK_KHZ_DIV2 half the mclk frequency in kHz (the wrap threshold)
//   DEFAULT_KHZ   output frequency loaded at reset
//   CNT_W         edge counter width
//
// Ports:
//   mclk             clock; all logic uses its rising edge
//   reset            synchronous, active-high reset
//   freq_khz         requested output frequency in kHz
//   freq_load        one-cycle strobe that captures freq_khz
//   freq_busy        high while a captured frequency waits to be applied
//   run              level request to generate the clock
//   osc_out          registered synthesized clock
//   osc_running      high whenever the state machine is not STOPPED
//   edge_count       osc_out rising-edge count (macro only)
//   edge_count_clear clears edge_count, overrides an increment (macro only)

module osc_synth #(
  parameter int ACC_W         = 16,
  parameter int MCLK_KHZ_DIV2 = 24000,
  parameter int DEFAULT_KHZ   = 1000,
  parameter int CNT_W         = 32
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [ACC_W-1:0] freq_khz,
  input  logic             freq_load,
  output logic             freq_busy,
  input  logic             run,
  output logic             osc_out,
  output logic             osc_running
`ifdef OSC_SYNTH_EDGE_COUNT_EN
  ,
  output logic [CNT_W-1:0] edge_count,
  input  logic             edge_count_clear
`endif
);

  // Threshold at the widened sum width, and at the frequency-word width
  // for clamping captured requests.
  localparam logic [ACC_W:0]   LIMIT   = (ACC_W+1)'(MCLK_KHZ_DIV2);
  localparam logic [ACC_W-1:0] LIMIT_W = ACC_W'(MCLK_KHZ_DIV2);
  localparam logic [ACC_W-1:0] STEP_RESET = ACC_W'(DEFAULT_KHZ);

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] accum_reg, accum_next;
  logic             toggle_reg, toggle_next;
  logic             osc_out_reg, osc_out_next;
  logic [ACC_W-1:0] step_reg;
  logic [ACC_W-1:0] pending_reg;
  logic             busy_reg;

  logic [ACC_W:0]   sum;
  logic             wrap;
  logic [ACC_W-1:0] accum_adv;
  logic             fall_ev;
  logic             stop_now;
  logic             apply_ev;
  logic [ACC_W-1:0] freq_clamped;

  // One extra bit so the sum can never wrap before the threshold compare.
  assign sum       = {1'b0, accum_reg} + {1'b0, step_reg};
  assign wrap      = (sum >= LIMIT);
  assign accum_adv = wrap ? ACC_W'(sum - LIMIT) : sum[ACC_W-1:0];

  // A toggle decided on the previous edge lands on osc_out this edge;
  // when osc_out is currently high that landing is a falling edge.
  assign fall_ev = toggle_reg & osc_out_reg;

  // Stop is allowed only when osc_out is already low or is falling now.
  assign stop_now = ~run & (~osc_out_reg | fall_ev);

  // Pending frequency is applied on a falling edge, or immediately when idle.
  assign apply_ev = busy_reg & (fall_ev | (state_reg == STOPPED));

  assign freq_clamped = (freq_khz > LIMIT_W) ? LIMIT_W : freq_khz;

  always_comb begin
    state_next   = state_reg;
    accum_next   = accum_reg;
    toggle_next  = toggle_reg;
    osc_out_next = osc_out_reg;
    case (state_reg)
      STOPPED: begin
        accum_next   = '0;
        toggle_next  = 1'b0;
        osc_out_next = 1'b0;
        if (run) begin
          state_next = RUNNING;
        end
      end
      RUNNING, STOPPING: begin
        if (stop_now) begin
          // Includes dropping a rise that was decided but not yet visible
          // while osc_out is low: stopping there leaves no runt pulse.
          state_next   = STOPPED;
          accum_next   = '0;
          toggle_next  = 1'b0;
          osc_out_next = 1'b0;
        end else begin
          accum_next   = accum_adv;
          toggle_next  = wrap;
          osc_out_next = osc_out_reg ^ toggle_reg;
          // run low here means osc_out is high and not yet falling.
          state_next   = run ? RUNNING : STOPPING;
        end
      end
      default: begin
        state_next   = STOPPED;
        accum_next   = '0;
        toggle_next  = 1'b0;
        osc_out_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_reg   <= STOPPED;
      accum_reg   <= '0;
      toggle_reg  <= 1'b0;
      osc_out_reg <= 1'b0;
      step_reg    <= STEP_RESET;
      pending_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      accum_reg   <= accum_next;
      toggle_reg  <= toggle_next;
      osc_out_reg <= osc_out_next;
      if (apply_ev) begin
        step_reg <= pending_reg;
        busy_reg <= 1'b0;
      end
      // A new load wins over a simultaneous apply: the old pending value
      // still moves to step, and the new one waits for the next chance.
      if (freq_load) begin
        pending_reg <= freq_clamped;
        busy_reg    <= 1'b1;
      end
    end
  end

  assign osc_out     = osc_out_reg;
  assign freq_busy   = busy_reg;
  assign osc_running = (state_reg != STOPPED);

`ifdef OSC_SYNTH_EDGE_COUNT_EN
  logic [CNT_W-1:0] edge_count_reg;
  logic             rise_ev;

  assign rise_ev = osc_out_next & ~osc_out_reg;

  always_ff @(posedge mclk) begin
    if (reset) begin
      edge_count_reg <= '0;
    end else if (edge_count_clear) begin
      edge_count_reg <= '0;
    end else if (rise_ev && (edge_count_reg != {CNT_W{1'b1}})) begin
      edge_count_reg <= edge_count_reg + 1'b1;
    end
  end

  assign edge_count = edge_count_reg;
`endif

endmodule

// File: tb/tb_osc_synth.sv
// Testbench for osc_synth: directed scenarios with hand-computed literal
// expectations, plus an integer reference model of the accumulator rules
// compared against the DUT outputs on every falling clock edge.
module tb_osc_synth;

  localparam int D = 24000;

  logic        mclk;
  logic        reset;
  logic [15:0] freq_khz;
  logic        freq_load;
  logic        freq_busy;
  logic        run;
  logic        osc_out;
  logic        osc_running;
  logic        edge_count_clear;
  logic [31:0] edge_count;

  int n_checks = 0;
  int n_errors = 0;

  osc_synth u_dut (
    .mclk            (mclk),
    .reset           (reset),
    .freq_khz        (freq_khz),
    .freq_load       (freq_load),
    .freq_busy       (freq_busy),
    .run             (run),
    .osc_out         (osc_out)
    ,.osc_running    (osc_running)
`ifdef OSC_SYNTH_EDGE_COUNT_EN
    ,.edge_count       (edge_count)
    ,.edge_count_clear (edge_count_clear)
`endif
  );

`ifdef OSC_SYNTH_EDGE_COUNT_EN
  logic       busy4, out4, running4;
  logic [3:0] edge_count4;
  osc_synth #(.CNT_W(4)) u_dut4 (
    .mclk             (mclk),
    .reset            (reset),
    .freq_khz         (freq_khz),
    .freq_load        (freq_load),
    .freq_busy        (busy4),
    .run              (run),
    .osc_out          (out4),
    .osc_running      (running4),
    .edge_count       (edge_count4),
    .edge_count_clear (edge_count_clear)
  );
`else
  assign edge_count = '0;
`endif

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase accumulator in plain integers. A wrap seen on an edge becomes
  // visible on osc_out one edge later (m_land). Modes: 0 idle, 1 run, 2 drain.
  int     m_mode, m_acc, m_out, m_land, m_step, m_pend, m_busy;
  longint m_cnt;

  always @(posedge mclk) begin
    int s, fell, prev, apply;
    if (reset) begin
      m_mode = 0; m_acc = 0; m_out = 0; m_land = 0;
      m_step = 1000; m_pend = 0; m_busy = 0; m_cnt = 0;
    end else begin
      prev  = m_out;
      fell  = (m_land == 1 && m_out == 1) ? 1 : 0;
      apply = (m_busy == 1 && (fell == 1 || m_mode == 0)) ? 1 : 0;
      if (m_mode == 0) begin
        m_acc = 0; m_out = 0; m_land = 0;
        if (run) m_mode = 1;
      end else if (!run && (m_out == 0 || fell == 1)) begin
        m_mode = 0; m_acc = 0; m_out = 0; m_land = 0;
      end else begin
        if (m_land == 1) m_out = 1 - m_out;
        s = m_acc + m_step;
        if (s >= D) begin m_land = 1; m_acc = s - D; end
        else        begin m_land = 0; m_acc = s;     end
        m_mode = run ? 1 : 2;
      end
      if (edge_count_clear) m_cnt = 0;
      else if (prev == 0 && m_out == 1 && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (apply == 1) begin m_step = m_pend; m_busy = 0; end
      if (freq_load) begin
        m_pend = (freq_khz > D) ? D : int'(freq_khz);
        m_busy = 1;
      end
    end
  end

  always @(negedge mclk) begin
    chk("cyc_osc_out", longint'(osc_out), longint'(m_out));
    chk("cyc_osc_running", longint'(osc_running), longint'(m_mode != 0));
    chk("cyc_freq_busy", longint'(freq_busy), longint'(m_busy));
`ifdef OSC_SYNTH_EDGE_COUNT_EN
    chk("cyc_edge_count", longint'(edge_count), m_cnt);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Edges waited until osc_out shows val (sampled just after each edge).
  task automatic wait_level(input logic val, output int n);
    n = 0;
    while (osc_out !== val) begin
      tick();
      n++;
      if (n > 400) begin
        chk("wait_timeout", longint'(osc_out), longint'(val));
        break;
      end
    end
  endtask

  task automatic do_load(input int v);
    freq_khz  = 16'(v);
    freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic count_toggles(input int cycles, output int t);
    logic p;
    t = 0;
    p = osc_out;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (osc_out !== p) t++;
      p = osc_out;
    end
  endtask

  initial begin
    int n, n2, t;
    reset = 1'b1; run = 1'b0; freq_load = 1'b0; freq_khz = '0;
    edge_count_clear = 1'b0;

    // Reset state
    do_reset();
    chk("reset_osc_out", longint'(osc_out), 0);
    chk("reset_running", longint'(osc_running), 0);
    chk("reset_busy", longint'(freq_busy), 0);
    $display("txn reset: osc_out=%0d running=%0d busy=%0d", osc_out, osc_running, freq_busy);

    // Default 1 MHz: first rise 25 cycles after run sampled, then 24/24
    run = 1'b1;
    tick();
    wait_level(1'b1, n);  chk("default_first_rise", n, 25);
    wait_level(1'b0, n);  chk("default_high", n, 24);
    wait_level(1'b1, n);  chk("default_low", n, 24);
    $display("txn default run: first rise, high and low measured");

    // 2000 kHz loaded while high: busy until the fall, then 12-cycle halves
    do_load(2000);
    chk("load2000_busy", longint'(freq_busy), 1);
    wait_level(1'b0, n);
    chk("load2000_busy_after_fall", longint'(freq_busy), 0);
    wait_level(1'b1, n);  chk("load2000_first_low", n, 13);
    wait_level(1'b0, n);  chk("load2000_high", n, 12);
    wait_level(1'b1, n);  chk("load2000_low", n, 12);
    $display("txn load 2000: half period %0d", n);

    // Overwrite while busy: 8000 then 4000, the last one wins
    do_load(8000);
    do_load(4000);
    chk("overwrite_busy", longint'(freq_busy), 1);
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    wait_level(1'b0, n);  chk("overwrite_high", n, 6);
    wait_level(1'b1, n);  chk("overwrite_low", n, 6);
    $display("txn overwrite 8000->4000: half period %0d", n);

    // 16000 kHz: two toggles every three cycles
    do_load(16000);
    wait_level(1'b0, n);
    repeat (3) tick();
    count_toggles(30, t);
    chk("f16000_toggles_30", t, 20);
    $display("txn load 16000: %0d toggles in 30 cycles", t);

    // 30000 kHz is clamped: toggles every cycle
    do_load(30000);
    wait_level(1'b1, n);
    wait_level(1'b0, n);
    chk("f30000_busy_cleared", longint'(freq_busy), 0);
    repeat (3) tick();
    count_toggles(10, t);
    chk("f30000_toggles_10", t, 10);
    $display("txn load 30000: %0d toggles in 10 cycles", t);

    // 0 kHz: osc_out freezes
    do_load(0);
    wait_level(1'b1, n);
    wait_level(1'b0, n);
    repeat (3) tick();
    count_toggles(50, t);
    chk("f0_toggles_50", t, 0);
    $display("txn load 0: %0d toggles in 50 cycles", t);

    // Reset beats a simultaneous load and the frozen run
    freq_khz = 16'd5000; freq_load = 1'b1; reset = 1'b1;
    tick();
    freq_load = 1'b0;
    tick();
    reset = 1'b0;
    run = 1'b0;
    chk("reset2_osc_out", longint'(osc_out), 0);
    chk("reset2_running", longint'(osc_running), 0);
    chk("reset2_busy", longint'(freq_busy), 0);
    run = 1'b1;
    tick();
    wait_level(1'b1, n);  chk("reset2_first_rise", n, 25);
    $display("txn reset over load: first rise %0d", n);

    // Stop mid-high, then stop/restart without a gap
    do_reset();
    run = 1'b1;
    tick();
    wait_level(1'b1, n);
    repeat (5) tick();
    run = 1'b0;
    wait_level(1'b0, n);  chk("stop_remaining_high", n, 19);
    chk("stop_running_low", longint'(osc_running), 0);
    run = 1'b1;
    tick();
    wait_level(1'b1, n);  chk("restart_first_rise", n, 25);
    repeat (3) tick();
    run = 1'b0;
    repeat (3) tick();
    chk("stopping_running", longint'(osc_running), 1);
    run = 1'b1;
    wait_level(1'b0, n);  chk("nogap_high", n + 6, 24);
    wait_level(1'b1, n);  chk("nogap_low", n, 24);
    $display("txn stop/restart: low %0d", n);

    // Loads while stopped, including one on the apply cycle
    run = 1'b0;
    wait_level(1'b0, n);
    tick();
    do_load(8000);
    chk("stopped_busy_1", longint'(freq_busy), 1);
    do_load(2000);
    chk("stopped_busy_coincident", longint'(freq_busy), 1);
    tick();
    chk("stopped_busy_cleared", longint'(freq_busy), 0);
    run = 1'b1;
    tick();
    wait_level(1'b1, n);  chk("stopped2000_first_rise", n, 13);
    $display("txn stopped loads: first rise %0d", n);

`ifdef OSC_SYNTH_EDGE_COUNT_EN
    // Edge counter: 10 rises, clear on a rise, saturation at CNT_W=4
    run = 1'b0;
    do_reset();
    do_load(12000);
    tick();
    run = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      wait_level(1'b1, n);
      if (i < 9) wait_level(1'b0, n);
    end
    chk("ec_ten_rises", longint'(edge_count), 10);
    do_load(30000);
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    wait_level(1'b0, n);
    chk("ec_busy_cleared", longint'(freq_busy), 0);
    repeat (2) tick();
    if (osc_out) tick();
    edge_count_clear = 1'b1;
    tick();
    edge_count_clear = 1'b0;
    chk("ec_clear_rise_out", longint'(osc_out), 1);
    chk("ec_clear_wins", longint'(edge_count), 0);
    n2 = 0;
    for (int i = 0; i < 45; i++) begin
      logic p;
      p = osc_out;
      tick();
      if (!p && osc_out) n2++;
    end
    chk("ec_count_after_clear", longint'(edge_count), n2);
    chk("ec_cnt4_saturated", longint'(edge_count4), 15);
    $display("txn edge count: rises=%0d count=%0d count4=%0d", n2, edge_count, edge_count4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
